// File: rtl/mouse_if.sv
// Mouse bundle between the quadrature/button tracker (master) and its consumer (slave).
// Raw device lines enter the master; position, button and status strobes leave it.
interface mouse_if #(
  parameter int WIDTH = 16
);
  logic             quad_a;
  logic             quad_b;
  logic             button_;
  logic [WIDTH-1:0] mouse_x;
  logic             mouse_pressed_;
  logic             mouse_step;
  logic             quad_error;

  modport master (
    input  quad_a, quad_b, button_,
    output mouse_x, mouse_pressed_, mouse_step, quad_error
  );

  modport slave (
    output quad_a, quad_b, button_,
    input  mouse_x, mouse_pressed_, mouse_step, quad_error
  );
endinterface

// File: rtl/mouse_tracker.sv
// Synchronises raw quadrature/button lines, decodes X motion into a saturating
// position with step/error strobes, and debounces the active-low button.
//
// state   | meaning
// --------+----------------------------------------------------------------
// ST_WARM | first 3 edges after reset: track prev only, no count, no flag
// ST_RUN  | decode quadrature transitions into +1 / -1 / illegal
module mouse_tracker #(
  parameter int WIDTH           = 16,
  parameter int X_MAX           = 639,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic     clock,
  input  logic     reset_,
  mouse_if.master  mif
);

  localparam int               CW      = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [WIDTH-1:0] X_MAX_W = WIDTH'(X_MAX);
  localparam logic [CW-1:0]    DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {ST_WARM, ST_RUN} state_e;

  state_e           state_q, state_d;
  logic [1:0]       warm_cnt_q, warm_cnt_d;
  logic [1:0]       a_sync_q, a_sync_d;
  logic [1:0]       b_sync_q, b_sync_d;
  logic [1:0]       btn_sync_q, btn_sync_d;
  logic [1:0]       prev_q, prev_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic             step_q, step_d;
  logic             err_q, err_d;
  logic             pressed_q, pressed_d;
  logic [CW-1:0]    db_cnt_q, db_cnt_d;

  logic [1:0]       cur;
  logic [1:0]       delta;

  // Gray position along the forward cycle 00 -> 01 -> 11 -> 10.
  function automatic logic [1:0] gray_idx(input logic [1:0] g);
    case (g)
      2'b00:   gray_idx = 2'd0;
      2'b01:   gray_idx = 2'd1;
      2'b11:   gray_idx = 2'd2;
      default: gray_idx = 2'd3;
    endcase
  endfunction

  assign cur   = {a_sync_q[1], b_sync_q[1]};
  assign delta = gray_idx(cur) - gray_idx(prev_q);

  always_comb begin
    a_sync_d   = {a_sync_q[0], mif.quad_a};
    b_sync_d   = {b_sync_q[0], mif.quad_b};
    btn_sync_d = {btn_sync_q[0], mif.button_};
  end

  always_comb begin
    state_d    = state_q;
    warm_cnt_d = warm_cnt_q;
    prev_d     = cur;
    x_d        = x_q;
    step_d     = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      ST_WARM: begin
        warm_cnt_d = warm_cnt_q + 2'd1;
        if (warm_cnt_q == 2'd2) state_d = ST_RUN;
      end
      ST_RUN: begin
        case (delta)
          2'd1: if (x_q != X_MAX_W) begin
            x_d    = x_q + 1'b1;
            step_d = 1'b1;
          end
          2'd3: if (x_q != '0) begin
            x_d    = x_q - 1'b1;
            step_d = 1'b1;
          end
          2'd2:    err_d = 1'b1;
          default: ;
        endcase
      end
      default: state_d = ST_WARM;
    endcase
  end

  // Counter tracks how long sync2 has disagreed with the accepted level.
  always_comb begin
    pressed_d = pressed_q;
    db_cnt_d  = '0;
    if (btn_sync_q[1] != pressed_q) begin
      if (db_cnt_q == DB_LAST) begin
        pressed_d = ~pressed_q;
        db_cnt_d  = '0;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state_q    <= ST_WARM;
      warm_cnt_q <= 2'd0;
      a_sync_q   <= 2'b00;
      b_sync_q   <= 2'b00;
      btn_sync_q <= 2'b11;
      prev_q     <= 2'b00;
      x_q        <= '0;
      step_q     <= 1'b0;
      err_q      <= 1'b0;
      pressed_q  <= 1'b1;
      db_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      warm_cnt_q <= warm_cnt_d;
      a_sync_q   <= a_sync_d;
      b_sync_q   <= b_sync_d;
      btn_sync_q <= btn_sync_d;
      prev_q     <= prev_d;
      x_q        <= x_d;
      step_q     <= step_d;
      err_q      <= err_d;
      pressed_q  <= pressed_d;
      db_cnt_q   <= db_cnt_d;
    end
  end

  assign mif.mouse_x        = x_q;
  assign mif.mouse_pressed_ = pressed_q;
  assign mif.mouse_step     = step_q;
  assign mif.quad_error     = err_q;

endmodule

// File: tb/tb_mouse_tracker.sv
// Scoreboard bench for mouse_tracker: stimulus pushes expected step/error/button
// events with their due cycle; a negedge monitor pops and compares them.
module tb_mouse_tracker;

  localparam int X_MAX = 639;

  logic clock = 1'b0;
  logic reset_;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  mouse_if #(.WIDTH(16)) mif ();

  mouse_tracker #(.WIDTH(16), .X_MAX(X_MAX), .DEBOUNCE_CYCLES(4)) dut (
    .clock  (clock),
    .reset_ (reset_),
    .mif    (mif.master)
  );

  typedef struct {bit is_err; int x; int cyc;} qev_t;
  typedef struct {bit val; int cyc;} bev_t;
  qev_t qq[$];
  bev_t bq[$];

  logic [1:0] qs;
  int         xm;
  logic       prev_p = 1'b1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  function automatic logic [1:0] nxt_fwd(input logic [1:0] s);
    case (s)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] nxt_rev(input logic [1:0] s);
    case (s)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  task automatic drive_q(input logic [1:0] s);
    qs = s;
    mif.quad_a = s[1];
    mif.quad_b = s[0];
  endtask

  // One legal step held 4 clocks; saturated moves expect no event.
  task automatic move(input bit fwd);
    qev_t e;
    drive_q(fwd ? nxt_fwd(qs) : nxt_rev(qs));
    if (fwd && xm < X_MAX) begin
      xm++;
      e.is_err = 1'b0; e.x = xm; e.cyc = cyc + 3; qq.push_back(e);
    end else if (!fwd && xm > 0) begin
      xm--;
      e.is_err = 1'b0; e.x = xm; e.cyc = cyc + 3; qq.push_back(e);
    end
    tick(4);
  endtask

  task automatic jump();
    qev_t e;
    drive_q(qs ^ 2'b11);
    e.is_err = 1'b1; e.x = xm; e.cyc = cyc + 3; qq.push_back(e);
    tick(4);
  endtask

  always @(negedge clock) begin
    if (!reset_) begin
      prev_p <= 1'b1;
    end else begin
      if (mif.mouse_step || mif.quad_error) begin
        chk("step_err_exclusive", int'(mif.mouse_step & mif.quad_error), 0);
        chk("x_in_range", int'(mif.mouse_x <= 16'(X_MAX)), 1);
        if (qq.size() == 0) begin
          chk("unexpected_quad_event_x", int'(mif.mouse_x), -1);
        end else begin
          qev_t e;
          e = qq.pop_front();
          chk("quad_event_kind_err", int'(mif.quad_error), int'(e.is_err));
          chk("quad_event_x", int'(mif.mouse_x), e.x);
          chk("quad_event_cycle", cyc, e.cyc);
        end
      end
      if (mif.mouse_pressed_ !== prev_p) begin
        if (bq.size() == 0) begin
          chk("unexpected_button_change", int'(mif.mouse_pressed_), int'(prev_p));
        end else begin
          bev_t b;
          b = bq.pop_front();
          chk("button_value", int'(mif.mouse_pressed_), int'(b.val));
          chk("button_cycle", cyc, b.cyc);
        end
      end
      prev_p <= mif.mouse_pressed_;
    end
  end

  initial begin
    bev_t b;
    reset_ = 1'b0;
    mif.button_ = 1'b1;
    drive_q(2'b11);
    xm = 0;
    tick(2);
    chk("reset_x", int'(mif.mouse_x), 0);
    chk("reset_pressed", int'(mif.mouse_pressed_), 1);
    chk("reset_step", int'(mif.mouse_step), 0);
    chk("reset_err", int'(mif.quad_error), 0);

    reset_ = 1'b1;
    tick(3);
    tick(2);
    chk("warmup_x", int'(mif.mouse_x), 0);

    repeat (10) move(1'b1);
    chk("x_after_10_fwd", int'(mif.mouse_x), 10);
    repeat (3) move(1'b0);
    chk("x_after_3_rev", int'(mif.mouse_x), 7);

    jump();
    chk("x_after_jump", int'(mif.mouse_x), 7);
    move(1'b1);
    chk("x_after_jump_fwd", int'(mif.mouse_x), 8);

    repeat (8) move(1'b0);
    chk("x_at_zero", int'(mif.mouse_x), 0);
    move(1'b0);
    chk("x_sat_low", int'(mif.mouse_x), 0);

    repeat (X_MAX) move(1'b1);
    chk("x_at_max", int'(mif.mouse_x), X_MAX);
    move(1'b1);
    chk("x_sat_high", int'(mif.mouse_x), X_MAX);

    repeat (X_MAX - 42) move(1'b0);
    chk("x_at_42", int'(mif.mouse_x), 42);

    mif.button_ = 1'b0;
    tick(3);
    mif.button_ = 1'b1;
    tick(8);
    chk("short_press_ignored", int'(mif.mouse_pressed_), 1);

    mif.button_ = 1'b0;
    b.val = 1'b0; b.cyc = cyc + 6; bq.push_back(b);
    tick(8);
    chk("held_press", int'(mif.mouse_pressed_), 0);
    mif.button_ = 1'b1;
    tick(2);
    mif.button_ = 1'b0;
    tick(8);
    chk("glitch_no_release", int'(mif.mouse_pressed_), 0);
    chk("btn_queue_drained", bq.size(), 0);

    drive_q(nxt_fwd(qs));
    tick(1);
    #1;
    reset_ = 1'b0;
    #1;
    chk("async_reset_x", int'(mif.mouse_x), 0);
    chk("async_reset_pressed", int'(mif.mouse_pressed_), 1);
    chk("async_reset_step", int'(mif.mouse_step), 0);
    qq.delete();
    bq.delete();
    xm = 0;
    mif.button_ = 1'b1;
    tick(2);
    reset_ = 1'b1;
    tick(5);
    chk("rewarm_x", int'(mif.mouse_x), 0);
    move(1'b1);
    chk("x_after_rewarm_fwd", int'(mif.mouse_x), 1);

    tick(4);
    chk("quad_queue_drained", qq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
